mem_access: RTL and testbench

//  RV32I memory stage. Sits between the ALU stage and writeback: latches the ALU-stage outputs and performs loads/stores over a single-outstanding req/ack data bus.

---
 rtl/mem_access_if.sv | 15 +
 rtl/mem_access.sv | 163 ++++++++++++++++
 tb/tb_mem_access.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Single-outstanding req/ack data bus between the memory stage and the data memory.
interface mem_access_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_STRB;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  modport master (output MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
                  input  MEM_ACK, MEM_RDATA);
  modport slave  (input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
                  output MEM_ACK, MEM_RDATA);
endinterface

// File: rtl/mem_access.sv
// RV32I memory stage: latches ALU-stage results, runs loads/stores over a req/ack bus,
// and drives the writeback bundle plus the forwarding path back to the ALU stage.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic [31:0] A_PC,
  input  logic [31:0] A_INST,
  input  logic        A_VALID,
  input  logic [4:0]  A_REG_D,
  input  logic [31:0] A_REG_D_V,
  input  logic        A_MEM_RE,
  input  logic        A_MEM_WE,
  input  logic [2:0]  A_MEM_FUNCT3,
  input  logic [31:0] A_MEM_ADDR,
  input  logic [31:0] A_MEM_WDATA,
  mem_access_if.master MEM,
  output logic [31:0] M_PC,
  output logic [31:0] M_INST,
  output logic        M_VALID,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V,
  output logic        M_BUSY,
  output logic [1:0]  M_EXC,
  output logic        FWD_M_VALID,
  output logic [4:0]  FWD_M_REG_D,
  output logic [31:0] FWD_M_REG_D_V
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << a;
      2'b01:   store_strb = 4'b0011 << a;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Halfwords are aligned here, so shifting by the byte offset also selects the right half.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  fmt_load = {24'h0, sh[7:0]};
      3'b101:  fmt_load = {16'h0, sh[15:0]};
      default: fmt_load = rd;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_q, res_d;
  logic [1:0]    exc_q, exc_d;
  logic [31:0]   pc_q, inst_q, addr_q, wdata_q;
  logic          valid_q, re_q, we_q;
  logic [4:0]    regd_q;
  logic [2:0]    f3_q;
  logic          load_en, a_mem, a_mis;

  // The latch never advances under a pending access, even if STALL is mis-wired.
  assign load_en = !STALL && (state_q != S_REQ);
  assign a_mem   = A_VALID && (A_MEM_RE || A_MEM_WE);
  assign a_mis   = a_mem && misaligned(A_MEM_FUNCT3, A_MEM_ADDR[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (state_q == S_REQ) begin
      if (MEM.MEM_ACK) begin
        state_d = S_DONE;
        res_d   = re_q ? fmt_load(f3_q, addr_q[1:0], MEM.MEM_RDATA) : 32'h0;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_DONE;
        res_d   = 32'h0;
        exc_d   = 2'b10;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (load_en) begin
      cnt_d   = '0;
      exc_d   = a_mis ? 2'b01 : 2'b00;
      res_d   = a_mem ? 32'h0 : A_REG_D_V;
      state_d = (a_mem && !a_mis) ? S_REQ : S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      exc_q   <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      regd_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      if (load_en) begin
        pc_q    <= A_PC;
        inst_q  <= A_INST;
        valid_q <= A_VALID;
        regd_q  <= A_REG_D;
        re_q    <= A_MEM_RE;
        we_q    <= A_MEM_WE;
        f3_q    <= A_MEM_FUNCT3;
        addr_q  <= A_MEM_ADDR;
        wdata_q <= A_MEM_WDATA;
      end
    end
  end

  assign MEM.MEM_REQ   = (state_q == S_REQ);
  assign MEM.MEM_WE    = (state_q == S_REQ) && we_q;
  assign MEM.MEM_ADDR  = {addr_q[31:2], 2'b00};
  assign MEM.MEM_STRB  = (state_q != S_REQ) ? 4'b0000 :
                         we_q ? store_strb(f3_q, addr_q[1:0]) : 4'b1111;
  assign MEM.MEM_WDATA = store_data(f3_q, wdata_q);

  assign M_PC          = pc_q;
  assign M_INST        = inst_q;
  assign M_VALID       = valid_q;
  assign M_REG_D       = regd_q;
  assign M_REG_D_V     = res_q;
  assign M_BUSY        = (state_q == S_REQ);
  assign M_EXC         = exc_q;
  assign FWD_M_VALID   = valid_q && (regd_q != 5'd0) && !M_BUSY && (exc_q == 2'b00);
  assign FWD_M_REG_D   = regd_q;
  assign FWD_M_REG_D_V = res_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU passthrough, load formatting, stores, exceptions, reset, stall.
module tb_mem_access;
  logic        CLK = 1'b0;
  logic        RST, stall_ext, STALL;
  logic [31:0] A_PC, A_INST, A_REG_D_V, A_MEM_ADDR, A_MEM_WDATA;
  logic        A_VALID, A_MEM_RE, A_MEM_WE;
  logic [4:0]  A_REG_D;
  logic [2:0]  A_MEM_FUNCT3;
  logic [31:0] M_PC, M_INST, M_REG_D_V, FWD_M_REG_D_V;
  logic        M_VALID, M_BUSY, FWD_M_VALID;
  logic [4:0]  M_REG_D, FWD_M_REG_D;
  logic [1:0]  M_EXC;
  int          checks = 0;
  int          errors = 0;

  mem_access_if bus ();

  assign STALL = stall_ext | M_BUSY;

  mem_access #(.TIMEOUT_CYCLES(256)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .A_PC(A_PC), .A_INST(A_INST), .A_VALID(A_VALID), .A_REG_D(A_REG_D),
    .A_REG_D_V(A_REG_D_V), .A_MEM_RE(A_MEM_RE), .A_MEM_WE(A_MEM_WE),
    .A_MEM_FUNCT3(A_MEM_FUNCT3), .A_MEM_ADDR(A_MEM_ADDR), .A_MEM_WDATA(A_MEM_WDATA),
    .MEM(bus),
    .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
    .M_REG_D_V(M_REG_D_V), .M_BUSY(M_BUSY), .M_EXC(M_EXC),
    .FWD_M_VALID(FWD_M_VALID), .FWD_M_REG_D(FWD_M_REG_D), .FWD_M_REG_D_V(FWD_M_REG_D_V)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic bubble;
    A_VALID = 0; A_MEM_RE = 0; A_MEM_WE = 0; A_MEM_FUNCT3 = 3'b000;
    A_REG_D = 0; A_REG_D_V = 0; A_MEM_ADDR = 0; A_MEM_WDATA = 0;
    A_PC = 0; A_INST = 32'h00000013;
  endtask

  // Issues one memory op, then services the bus; ack_at = REQ cycle that sees ACK (0 = never).
  task automatic run_mem(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_at,
                         output int busy, output logic [3:0] strb,
                         output logic [31:0] baddr, output logic [31:0] bwdata,
                         output logic bwe);
    A_VALID = 1; A_MEM_RE = re; A_MEM_WE = we; A_MEM_FUNCT3 = f3;
    A_MEM_ADDR = addr; A_MEM_WDATA = wd; A_REG_D = re ? 5'd5 : 5'd0;
    A_REG_D_V = 32'h11111111; A_PC = 32'h80; A_INST = 32'h0;
    step;
    bubble;
    busy = 0; strb = 0; baddr = 0; bwdata = 0; bwe = 0;
    for (int i = 0; i < 400; i++) begin
      if (!M_BUSY) break;
      busy++;
      if (busy == 1) begin
        strb = bus.MEM_STRB; baddr = bus.MEM_ADDR; bwdata = bus.MEM_WDATA; bwe = bus.MEM_WE;
      end
      if (busy == ack_at) begin
        bus.MEM_ACK = 1; bus.MEM_RDATA = rd;
      end
      step;
      bus.MEM_ACK = 0; bus.MEM_RDATA = 0;
    end
  endtask

  task automatic test_reset;
    RST = 1; step; step;
    checks++; if (M_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", M_VALID); end
    checks++; if (M_REG_D_V !== 32'h0) begin errors++; $display("FAIL rst_regdv got %h exp 0", M_REG_D_V); end
    checks++; if (bus.MEM_REQ !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.MEM_REQ); end
    checks++; if ({M_BUSY, M_EXC, FWD_M_VALID} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {M_BUSY, M_EXC, FWD_M_VALID}); end
    RST = 0;
  endtask

  task automatic test_alu;
    A_VALID = 1; A_REG_D = 5'd3; A_REG_D_V = 32'd7; A_PC = 32'h40;
    step;
    bubble;
    checks++; if (FWD_M_VALID !== 1'b1) begin errors++; $display("FAIL alu_fwd_valid got %b exp 1", FWD_M_VALID); end
    checks++; if (FWD_M_REG_D !== 5'd3) begin errors++; $display("FAIL alu_fwd_rd got %0d exp 3", FWD_M_REG_D); end
    checks++; if (FWD_M_REG_D_V !== 32'd7) begin errors++; $display("FAIL alu_fwd_val got %h exp 7", FWD_M_REG_D_V); end
    checks++; if (M_PC !== 32'h40) begin errors++; $display("FAIL alu_pc got %h exp 40", M_PC); end
    checks++; if (bus.MEM_REQ !== 1'b0) begin errors++; $display("FAIL alu_req got %b exp 0", bus.MEM_REQ); end
  endtask

  task automatic test_lw;
    int busy; logic [3:0] s; logic [31:0] a, w; logic we;
    run_mem(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, busy, s, a, w, we);
    checks++; if (busy !== 3) begin errors++; $display("FAIL lw_busy got %0d exp 3", busy); end
    checks++; if (a !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 100", a); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL lw_we got %b exp 0", we); end
    checks++; if (M_REG_D_V !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", M_REG_D_V); end
    checks++; if (FWD_M_VALID !== 1'b1) begin errors++; $display("FAIL lw_fwd got %b exp 1", FWD_M_VALID); end
  endtask

  task automatic test_load_format;
    int busy; logic [3:0] s; logic [31:0] a, w; logic we;
    run_mem(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 1, busy, s, a, w, we);
    checks++; if (M_REG_D_V !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h exp ffffff80", M_REG_D_V); end
    checks++; if (busy !== 1) begin errors++; $display("FAIL lb_busy got %0d exp 1", busy); end
    run_mem(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 1, busy, s, a, w, we);
    checks++; if (M_REG_D_V !== 32'h00000080) begin errors++; $display("FAIL lbu got %h exp 00000080", M_REG_D_V); end
    run_mem(1, 0, 3'b001, 32'h102, 0, 32'h80011234, 1, busy, s, a, w, we);
    checks++; if (M_REG_D_V !== 32'hFFFF8001) begin errors++; $display("FAIL lh got %h exp ffff8001", M_REG_D_V); end
    run_mem(1, 0, 3'b101, 32'h102, 0, 32'h80011234, 2, busy, s, a, w, we);
    checks++; if (M_REG_D_V !== 32'h00008001) begin errors++; $display("FAIL lhu got %h exp 00008001", M_REG_D_V); end
    run_mem(1, 0, 3'b000, 32'h101, 0, 32'h1234F600, 1, busy, s, a, w, we);
    checks++; if (M_REG_D_V !== 32'hFFFFFFF6) begin errors++; $display("FAIL lb1 got %h exp fffffff6", M_REG_D_V); end
  endtask

  task automatic test_store;
    int busy; logic [3:0] s; logic [31:0] a, w; logic we;
    run_mem(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 1, busy, s, a, w, we);
    checks++; if (s !== 4'b0010) begin errors++; $display("FAIL sb_strb got %b exp 0010", s); end
    checks++; if (w[15:8] !== 8'hAB) begin errors++; $display("FAIL sb_wdata got %h exp ab", w[15:8]); end
    checks++; if (a !== 32'h200) begin errors++; $display("FAIL sb_addr got %h exp 200", a); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL sb_we got %b exp 1", we); end
    run_mem(0, 1, 3'b001, 32'h202, 32'hFFFF1234, 0, 2, busy, s, a, w, we);
    checks++; if ({s, w[31:16]} !== {4'b1100, 16'h1234}) begin errors++; $display("FAIL sh got %b/%h exp 1100/1234", s, w[31:16]); end
    run_mem(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 1, busy, s, a, w, we);
    checks++; if ({s, w} !== {4'b1111, 32'hCAFEF00D}) begin errors++; $display("FAIL sw got %b/%h exp 1111/cafef00d", s, w); end
  endtask

  task automatic test_misaligned;
    A_VALID = 1; A_MEM_RE = 1; A_MEM_FUNCT3 = 3'b010; A_MEM_ADDR = 32'h102; A_REG_D = 5'd6;
    step;
    bubble;
    checks++; if (bus.MEM_REQ !== 1'b0) begin errors++; $display("FAIL mis_req got %b exp 0", bus.MEM_REQ); end
    checks++; if (M_EXC !== 2'b01) begin errors++; $display("FAIL mis_exc got %b exp 01", M_EXC); end
    checks++; if ({M_BUSY, FWD_M_VALID} !== 2'b00) begin errors++; $display("FAIL mis_busy_fwd got %b exp 00", {M_BUSY, FWD_M_VALID}); end
    checks++; if (M_REG_D_V !== 32'h0) begin errors++; $display("FAIL mis_val got %h exp 0", M_REG_D_V); end
    A_VALID = 1; A_MEM_WE = 1; A_MEM_FUNCT3 = 3'b001; A_MEM_ADDR = 32'h301;
    step;
    bubble;
    checks++; if ({bus.MEM_REQ, M_EXC} !== 3'b001) begin errors++; $display("FAIL mis_sh got %b exp 001", {bus.MEM_REQ, M_EXC}); end
    A_VALID = 0; A_MEM_RE = 1; A_MEM_FUNCT3 = 3'b010; A_MEM_ADDR = 32'h100;
    step;
    bubble;
    checks++; if ({bus.MEM_REQ, M_EXC, M_BUSY} !== 4'b0000) begin errors++; $display("FAIL invalid_op got %b exp 0000", {bus.MEM_REQ, M_EXC, M_BUSY}); end
  endtask

  task automatic test_timeout;
    int busy; logic [3:0] s; logic [31:0] a, w; logic we;
    run_mem(1, 0, 3'b010, 32'h100, 0, 32'h12345678, 0, busy, s, a, w, we);
    checks++; if (busy !== 256) begin errors++; $display("FAIL to_cycles got %0d exp 256", busy); end
    checks++; if (M_EXC !== 2'b10) begin errors++; $display("FAIL to_exc got %b exp 10", M_EXC); end
    checks++; if ({bus.MEM_REQ, FWD_M_VALID} !== 2'b00) begin errors++; $display("FAIL to_req_fwd got %b exp 00", {bus.MEM_REQ, FWD_M_VALID}); end
    checks++; if (M_REG_D_V !== 32'h0) begin errors++; $display("FAIL to_val got %h exp 0", M_REG_D_V); end
  endtask

  task automatic test_rst_mid;
    A_VALID = 1; A_MEM_RE = 1; A_MEM_FUNCT3 = 3'b010; A_MEM_ADDR = 32'h100; A_REG_D = 5'd5; A_PC = 32'h44;
    step;
    bubble;
    checks++; if (bus.MEM_REQ !== 1'b1) begin errors++; $display("FAIL rm_req_on got %b exp 1", bus.MEM_REQ); end
    step;
    RST = 1;
    step;
    RST = 0;
    checks++; if ({bus.MEM_REQ, M_BUSY, M_VALID} !== 3'b000) begin errors++; $display("FAIL rm_after got %b exp 000", {bus.MEM_REQ, M_BUSY, M_VALID}); end
    checks++; if ({M_PC, M_REG_D_V} !== 64'h0) begin errors++; $display("FAIL rm_outs got %h exp 0", {M_PC, M_REG_D_V}); end
    bus.MEM_ACK = 1; bus.MEM_RDATA = 32'hDEADBEEF;
    step;
    bus.MEM_ACK = 0; bus.MEM_RDATA = 0;
    checks++; if ({bus.MEM_REQ, M_REG_D_V} !== 33'h0) begin errors++; $display("FAIL rm_late_ack got %h exp 0", {bus.MEM_REQ, M_REG_D_V}); end
  endtask

  task automatic test_stall_done;
    int busy; logic [3:0] s; logic [31:0] a, w; logic we;
    run_mem(1, 0, 3'b010, 32'h400, 0, 32'h12345678, 1, busy, s, a, w, we);
    stall_ext = 1;
    A_VALID = 1; A_MEM_RE = 1; A_MEM_FUNCT3 = 3'b010; A_MEM_ADDR = 32'h500; A_REG_D = 5'd7;
    step; step;
    checks++; if ({M_REG_D_V, M_REG_D} !== {32'h12345678, 5'd5}) begin errors++; $display("FAIL st_hold got %h/%0d exp 12345678/5", M_REG_D_V, M_REG_D); end
    checks++; if (bus.MEM_REQ !== 1'b0) begin errors++; $display("FAIL st_req got %b exp 0", bus.MEM_REQ); end
    A_MEM_RE = 0; A_MEM_ADDR = 0; A_REG_D_V = 32'h99;
    stall_ext = 0;
    step;
    bubble;
    checks++; if ({M_REG_D_V, M_REG_D, FWD_M_VALID} !== {32'h99, 5'd7, 1'b1}) begin errors++; $display("FAIL st_release got %h/%0d/%b exp 99/7/1", M_REG_D_V, M_REG_D, FWD_M_VALID); end
  endtask

  initial begin
    RST = 1; stall_ext = 0;
    bus.MEM_ACK = 0; bus.MEM_RDATA = 0;
    bubble;
    test_reset;
    test_alu;
    test_lw;
    test_load_format;
    test_store;
    test_misaligned;
    test_timeout;
    test_rst_mid;
    test_stall_done;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
